// File: rtl/cordic_pkg.sv
// cordic_pkg: shared CORDIC angle format, arctangent table, gain constant and FSM states
package cordic_pkg;
  localparam int ANGLE_WIDTH = 32;
  localparam logic [31:0] KINV = 32'h9B74EDA8;
  localparam logic [31:0] ATAN [32] = '{
    32'd1073741824, 32'd633866811, 32'd334917815, 32'd170009512,
    32'd85334662,   32'd42708931,  32'd21359677,  32'd10680490,
    32'd5340327,    32'd2670173,   32'd1335088,   32'd667544,
    32'd333772,     32'd166886,    32'd83443,     32'd41722,
    32'd20861,      32'd10430,     32'd5215,      32'd2608,
    32'd1304,       32'd652,       32'd326,       32'd163,
    32'd81,         32'd41,        32'd20,        32'd10,
    32'd5,          32'd3,         32'd1,         32'd1
  };
  typedef enum logic [1:0] {IDLE, ROTATE, SCALE, DONE} state_t;
endpackage

// File: rtl/cordic_vector_stage.sv
// cordic_vector_stage: one combinational vectoring micro-rotation driving y toward zero
module cordic_vector_stage
  import cordic_pkg::*;
(
  input  logic signed [33:0] x,
  input  logic signed [33:0] y,
  input  logic [31:0]        z,
  input  logic [4:0]         i,
  output logic signed [33:0] nx,
  output logic signed [33:0] ny,
  output logic [31:0]        nz
);
  logic signed [33:0] xs, ys;
  logic neg;
  // rotate against the sign of y and book the rotation angle into z
  always_comb begin
    xs = x >>> i;
    ys = y >>> i;
    neg = y[33];
    nx = neg ? x - ys : x + ys;
    ny = neg ? y + xs : y - xs;
    nz = neg ? z - ATAN[i] : z + ATAN[i];
  end
endmodule

// File: rtl/cordic_arctan.sv
// cordic_arctan: iterative vectoring CORDIC producing atan(y/x) and gain-compensated magnitude
module cordic_arctan
  import cordic_pkg::*;
#(
  parameter int ITERATIONS = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [31:0]            x,
  input  logic [31:0]            y,
  output logic                   ready,
  output logic                   done,
  output logic [ANGLE_WIDTH-1:0] angle,
  output logic [31:0]            magnitude
);
  state_t state;
  logic [4:0] cnt;
  logic signed [33:0] xr, yr, nx, ny, xe, ye, yabs;
  logic [31:0] zr, nz;
  logic zx;
  logic [63:0] prod;
  assign xe = {{2{x[31]}}, x};
  assign ye = {{2{y[31]}}, y};
  assign ready = state == IDLE;
  assign yabs = yr[33] ? -yr : yr;
  assign prod = 64'($unsigned(xr)) * 64'(KINV);
  cordic_vector_stage u_stage (
    .x(xr), .y(yr), .z(zr), .i(cnt),
    .nx(nx), .ny(ny), .nz(nz)
  );
  // capture, iterate, scale and hand-shake the result; x==0 bypasses rotation and keeps y intact
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      xr <= '0;
      yr <= '0;
      zr <= '0;
      zx <= 1'b0;
      done <= 1'b0;
      angle <= '0;
      magnitude <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          xr <= x[31] ? -xe : xe;
          yr <= x[31] ? -ye : ye;
          zr <= '0;
          cnt <= '0;
          zx <= x == 32'd0;
          state <= ROTATE;
        end
        ROTATE: begin
          if (!zx) begin
            xr <= nx;
            yr <= ny;
            zr <= nz;
          end
          if (cnt == 5'(ITERATIONS - 1)) state <= SCALE;
          else cnt <= cnt + 5'd1;
        end
        SCALE: begin
          angle <= !zx ? zr : yr[33] ? 32'h80000000 : |yr ? 32'h7FFFFFFF : 32'h0;
          magnitude <= zx ? 32'(yabs) : 32'(prod >> 32);
          state <= DONE;
        end
        DONE: begin
          if (!done) done <= 1'b1;
          else if (!start) begin
            done <= 1'b0;
            state <= IDLE;
          end
        end
      endcase
    end
  end
endmodule
